ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
// - AHB-Lite responder: word-organised on-chip SRAM on one decoder slave slot.
// - Drives the Hrdata_S/Hresp_S/Hreadyout_S triplet into the slave-to-master response mux.
// - Supports programmable wait states, byte/halfword/word writes and the two-cycle ERROR response.
// PARAMETERS
// - DATA_WIDTH   32   data bus width; fixed at 32 for this block.
// - ADDR_WIDTH   32   Haddr width.
// - MEM_DEPTH    256  number of 32-bit words; word index = Haddr[ADDR_WIDTH-1:2].
// - WAIT_STATES  0    Hreadyout-low cycles inserted per OKAY data phase (0..15).
// PORTS
// - Hclk       in   1           clock, rising edge.
// - Hresetn    in   1           reset, asynchronous, active-low.
// - Hsel       in   1           slot select from the decoder.
// - Haddr      in   ADDR_WIDTH  transfer address.
// - Htrans     in   2           00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
// - Hwrite     in   1           1 = write.
// - Hsize      in   3           000 byte, 001 half, 010 word; others are illegal.
// - Hwdata     in   DATA_WIDTH  write data, valid in the data phase.
// - Hready     in   1           global Hready returned from the response mux.
// - Hreadyout  out  1           this slave's ready.
// - Hresp      out  2           00 OKAY, 01 ERROR.
// - Hrdata     out  DATA_WIDTH  read data.
// BEHAVIOUR
// - Reset state:
//   - Hreadyout=1, Hresp=00, Hrdata=0, FSM=IDLE, wait counter=0.
//   - Registered address-phase fields are cleared. SRAM contents are not reset.
// - Address-phase accept: Hsel & Hready & Htrans[1] at a rising edge.
//   - Registers addr_q, write_q, size_q and err_q.
// - Error (err_q=1) when any of these holds:
//   - word index >= MEM_DEPTH;
//   - Hsize > 010;
//   - half access with Haddr[0]=1;
//   - word access with Haddr[1:0]!=00.
// - IDLE or BUSY with Hsel=1, or Hsel=0: no access; next state IDLE; response OKAY, zero wait.
// - FSM states and outputs:
//   - IDLE  Hreadyout=1, Hresp=00.
//   - WAIT  Hreadyout=0, Hresp=00; wait counter decrements each cycle.
//   - DATA  Hreadyout=1, Hresp=00; completing data phase.
//   - ERR1  Hreadyout=0, Hresp=01.
//   - ERR2  Hreadyout=1, Hresp=01.
// - Transitions on accept:
//   - err -> ERR1.
//   - else WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
//   - else -> DATA.
// - Other transitions:
//   - WAIT -> DATA when counter==0.
//   - ERR1 -> ERR2 (always).
//   - DATA or ERR2 -> accepting state of any new transfer sampled on the same edge, else IDLE.
// - Pipelining: a new address phase may be accepted on the edge that completes DATA or ERR2.
//   - Back-to-back zero-wait transfers therefore sustain 1 transfer/cycle.
//   - No address phase is accepted while Hreadyout=0, because Hready is low in that case.
// - Write: mem[addr_q] is updated at the rising edge ending DATA, using Hwdata byte lanes.
//   - byte: lane addr_q[1:0].
//   - half: lanes {addr_q[1],0} and {addr_q[1],1}.
//   - word: all four lanes.
//   - Other lanes are unchanged. An errored transfer never writes.
// - Read:
//   - In DATA, Hrdata = mem[addr_q] as a full word; the master extracts lanes.
//   - In all other states Hrdata=0.
//   - Read in the cycle after a write to the same word returns the new data.
// - Latency: read/write data phase = 1+WAIT_STATES cycles; error = exactly 2 cycles.
// - Hreadyout depends only on FSM state; it has no combinational path from inputs.
// - Reset asserted mid-transfer:
//   - Immediately returns to IDLE with reset output values.
//   - An in-flight write is dropped; SRAM is otherwise intact.
// TESTING
// - WAIT_STATES=0; write word 0x0000_0010 <- 0xCAFEF00D, then read 0x10.
//   - Each data phase is 1 cycle with Hreadyout=1 and Hresp=00.
//   - Hrdata=0xCAFEF00D.
// - WAIT_STATES=2; read 0x10.
//   - Hreadyout=0 for 2 cycles, then 1 with Hrdata valid; Hresp=00 throughout.
// - Byte write 0xAB to 0x11 over 0xCAFEF00D.
//   - Read 0x10 returns 0xCAFEAB0D.
//   - Half write 0x1234 to 0x12 then gives 0x1234AB0D.
// - Word access at 0x13, then a word access at MEM_DEPTH*4.
//   - Each yields Hreadyout 0 then 1, with Hresp=01 on both cycles.
//   - No memory change.
// - Pipelined NONSEQ write 0x20 -> read 0x20 -> IDLE, zero wait.
//   - The read returns the written value in the 3rd cycle.
//   - Htrans=BUSY / Hsel=0 cycles give OKAY, zero wait.
// - Assert Hresetn during the WAIT of a write.
//   - Outputs return to reset values at once; the target word is unchanged on the following read.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between one decoder slot and its SRAM responder.
// The master side also drives the global Hready returned from the response mux.
interface ahb_sram_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  Hsel;
    logic [ADDR_WIDTH-1:0] Haddr;
    logic [1:0]            Htrans;
    logic                  Hwrite;
    logic [2:0]            Hsize;
    logic [DATA_WIDTH-1:0] Hwdata;
    logic                  Hready;
    logic                  Hreadyout;
    logic [1:0]            Hresp;
    logic [DATA_WIDTH-1:0] Hrdata;

    modport master (
        output Hsel, Haddr, Htrans, Hwrite, Hsize, Hwdata, Hready,
        input  Hreadyout, Hresp, Hrdata
    );

    modport slave (
        input  Hsel, Haddr, Htrans, Hwrite, Hsize, Hwdata, Hready,
        output Hreadyout, Hresp, Hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory with programmable wait states,
// byte/half/word writes and the two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic            Hclk,
    input  logic            Hresetn,
    ahb_sram_slave_if.slave bus
);
    localparam int unsigned IdxW = $clog2(MEM_DEPTH);
    localparam int unsigned AW   = IdxW + 2;
    localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {StIdle, StWait, StData, StErr1, StErr2} state_e;

    state_e          state_q, state_d, accept_state;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q;
    logic            write_q;
    logic [2:0]      size_q;
    logic            err_q;
    logic            accept, err_in, mem_we;
    logic [3:0]      be;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_comb begin
        accept = bus.Hsel & bus.Hready & (bus.Htrans inside {2'b10, 2'b11});
        err_in = (bus.Haddr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_DEPTH))
               | (bus.Hsize > 3'b010)
               | ((bus.Hsize == 3'b001) & bus.Haddr[0])
               | ((bus.Hsize == 3'b010) & (bus.Haddr[1:0] != 2'b00));
        if (err_in) begin
            accept_state = StErr1;
        end else if (WAIT_STATES > 0) begin
            accept_state = StWait;
        end else begin
            accept_state = StData;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle, StData, StErr2: begin
                state_d = accept ? accept_state : StIdle;
                if (accept && !err_in) begin
                    cnt_d = WaitLoad;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.Haddr[AW-1:0];
                write_q <= bus.Hwrite;
                size_q  <= bus.Hsize;
                err_q   <= err_in;
            end
        end
    end

    // Byte lanes of the registered access; errored sizes never reach DATA.
    always_comb begin
        case (size_q)
            3'b000:  be = 4'b0001 << addr_q[1:0];
            3'b001:  be = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        mem_we = (state_q == StData) & write_q & ~err_q;
    end

    always_ff @(posedge Hclk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[addr_q[AW-1:2]][8*i +: 8] <= bus.Hwdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        bus.Hreadyout = !(state_q inside {StWait, StErr1});
        bus.Hresp     = {1'b0, state_q inside {StErr1, StErr2}};
        bus.Hrdata    = (state_q == StData) ? mem[addr_q[AW-1:2]] : '0;
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one zero-wait and one two-wait SRAM slave share stimulus;
// 'which' picks the selected slave and the observed response.
module tb_ahb_sram_slave;
    localparam logic [1:0] TrIdle = 2'b00, TrBusy = 2'b01, TrNseq = 2'b10;
    localparam logic [2:0] SzByte = 3'b000, SzHalf = 3'b001, SzWord = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        which = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] addr = '0;
    logic [1:0]  trans = TrIdle;
    logic        write = 1'b0;
    logic [2:0]  size = SzWord;
    logic [31:0] wdata = '0;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    ahb_sram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus0 ();
    ahb_sram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

    assign bus0.Hsel   = sel & ~which;
    assign bus2.Hsel   = sel & which;
    assign bus0.Haddr  = addr;
    assign bus2.Haddr  = addr;
    assign bus0.Htrans = trans;
    assign bus2.Htrans = trans;
    assign bus0.Hwrite = write;
    assign bus2.Hwrite = write;
    assign bus0.Hsize  = size;
    assign bus2.Hsize  = size;
    assign bus0.Hwdata = wdata;
    assign bus2.Hwdata = wdata;
    assign bus0.Hready = bus0.Hreadyout;
    assign bus2.Hready = bus2.Hreadyout;

    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .Hclk    (clk),
        .Hresetn (rst_n),
        .bus     (bus0)
    );

    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) u_dut2 (
        .Hclk    (clk),
        .Hresetn (rst_n),
        .bus     (bus2)
    );

    wire        rdy   = which ? bus2.Hreadyout : bus0.Hreadyout;
    wire [1:0]  resp  = which ? bus2.Hresp     : bus0.Hresp;
    wire [31:0] rdata = which ? bus2.Hrdata    : bus0.Hrdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single NONSEQ transfer from an idle bus; returns data-phase observations.
    task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd, output logic [31:0] rd, output int waits,
                           output logic [1:0] resp_first, output logic [1:0] resp_last);
        sel   = 1'b1;
        trans = TrNseq;
        write = wr;
        addr  = a;
        size  = sz;
        tick();
        sel        = 1'b0;
        trans      = TrIdle;
        wdata      = wd;
        waits      = 0;
        resp_first = resp;
        while (!rdy && waits < 20) begin
            waits++;
            tick();
        end
        rd        = rdata;
        resp_last = resp;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          w;
        logic [1:0]  r0, r1;

        #2;
        check("rst_rdy0", rdy, 1);
        check("rst_resp0", resp, 0);
        check("rst_rdata0", rdata, 0);
        which = 1'b1;
        #1;
        check("rst_rdy2", rdy, 1);
        check("rst_rdata2", rdata, 0);
        which = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        do_xfer(1, 32'h10, SzWord, 32'hCAFEF00D, rd, w, r0, r1);
        check("w0_waits", w, 0);
        check("w0_resp", r1, 0);
        do_xfer(0, 32'h10, SzWord, 32'h0, rd, w, r0, r1);
        check("r0_waits", w, 0);
        check("r0_resp", r0, 0);
        check("r0_data", rd, 32'hCAFEF00D);

        do_xfer(1, 32'h11, SzByte, 32'h0000AB00, rd, w, r0, r1);
        do_xfer(0, 32'h10, SzWord, 32'h0, rd, w, r0, r1);
        check("byte_data", rd, 32'hCAFEAB0D);
        do_xfer(1, 32'h12, SzHalf, 32'h12340000, rd, w, r0, r1);
        do_xfer(0, 32'h10, SzWord, 32'h0, rd, w, r0, r1);
        check("half_data", rd, 32'h1234AB0D);

        do_xfer(1, 32'h13, SzWord, 32'hFFFFFFFF, rd, w, r0, r1);
        check("mis_waits", w, 1);
        check("mis_resp1", r0, 1);
        check("mis_resp2", r1, 1);
        check("mis_rdata", rd, 0);
        do_xfer(0, 32'h10, SzWord, 32'h0, rd, w, r0, r1);
        check("mis_nochg", rd, 32'h1234AB0D);

        do_xfer(1, 32'h0, SzWord, 32'h11111111, rd, w, r0, r1);
        do_xfer(1, 32'h400, SzWord, 32'hDEADBEEF, rd, w, r0, r1);
        check("oor_waits", w, 1);
        check("oor_resp1", r0, 1);
        check("oor_resp2", r1, 1);
        do_xfer(0, 32'h0, SzWord, 32'h0, rd, w, r0, r1);
        check("oor_nochg", rd, 32'h11111111);

        do_xfer(1, 32'h11, SzByte, 32'h0, rd, w, r0, r1);
        check("size_ok_waits", w, 0);
        do_xfer(0, 32'h10, SzHalf, 32'h0, rd, w, r0, r1);
        check("bad_size_half_al", r1, 0);
        do_xfer(0, 32'h10, 3'b011, 32'h0, rd, w, r0, r1);
        check("bad_size_resp", r0, 1);
        do_xfer(0, 32'h11, SzHalf, 32'h0, rd, w, r0, r1);
        check("half_mis_resp", r0, 1);

        // Pipelined write then read of the same word, zero wait.
        sel   = 1'b1;
        trans = TrNseq;
        write = 1'b1;
        addr  = 32'h20;
        size  = SzWord;
        tick();
        check("pipe_wr_rdy", rdy, 1);
        wdata = 32'h5A5A1234;
        write = 1'b0;
        tick();
        check("pipe_rd_rdy", rdy, 1);
        check("pipe_rd_resp", resp, 0);
        check("pipe_rd_data", rdata, 32'h5A5A1234);
        trans = TrIdle;
        tick();
        check("pipe_idle_rdy", rdy, 1);
        check("pipe_idle_rdata", rdata, 0);
        trans = TrBusy;
        tick();
        check("busy_rdy", rdy, 1);
        check("busy_resp", resp, 0);
        check("busy_rdata", rdata, 0);
        sel   = 1'b0;
        trans = TrNseq;
        tick();
        check("nosel_rdy", rdy, 1);
        check("nosel_rdata", rdata, 0);
        trans = TrIdle;
        tick();

        which = 1'b1;
        do_xfer(1, 32'h10, SzWord, 32'hCAFEF00D, rd, w, r0, r1);
        check("ws2_w_waits", w, 2);
        do_xfer(0, 32'h10, SzWord, 32'h0, rd, w, r0, r1);
        check("ws2_r_waits", w, 2);
        check("ws2_r_resp1", r0, 0);
        check("ws2_r_resp2", r1, 0);
        check("ws2_r_data", rd, 32'hCAFEF00D);

        // Reset while a write sits in WAIT.
        sel   = 1'b1;
        trans = TrNseq;
        write = 1'b1;
        addr  = 32'h10;
        size  = SzWord;
        tick();
        check("rstw_pre_rdy", rdy, 0);
        sel   = 1'b0;
        trans = TrIdle;
        wdata = 32'h0BADBEEF;
        rst_n = 1'b0;
        #1;
        check("rstw_rdy", rdy, 1);
        check("rstw_resp", resp, 0);
        check("rstw_rdata", rdata, 0);
        #2;
        rst_n = 1'b1;
        tick();
        do_xfer(0, 32'h10, SzWord, 32'h0, rd, w, r0, r1);
        check("rstw_nochg", rd, 32'hCAFEF00D);
        which = 1'b0;
        do_xfer(0, 32'h20, SzWord, 32'h0, rd, w, r0, r1);
        check("rstw_other", rd, 32'h5A5A1234);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
